// File: rtl/ps2_kbd_fifo_pkg.sv
// ps2_kbd_fifo_pkg
//   Shared constants, the queued-entry type and the frame check helper for
//   the PS/2 keyboard receiver.
package ps2_kbd_fifo_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;
    localparam int         PS2_ENTRY_W    = 10;

    // One queued code: prefix flags folded in front of the scan code.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

    // sr holds the first ten frame bits with the start bit in sr[0], data
    // in sr[8:1] (LSB first) and parity in sr[9]; stop is the 11th bit.
    // Parity is odd over data plus parity bit.
    function automatic logic ps2_frame_ok(input logic [9:0] sr, input logic stop);
        return (sr[0] == 1'b0) && stop && (^sr[9:1]);
    endfunction

endpackage

// File: rtl/ps2_kbd_fifo_if.sv
// ps2_kbd_fifo_if
//   Read side of the decoded scan-code queue.
//   Signals: rd_en (pop request), rd_valid (queue not empty), rd_data /
//   rd_break / rd_ext (head entry), count (entries queued).
//   Modports: slave = the queue (ps2_kbd_fifo), master = the consumer.
//
//   Handshake: the queue raises rd_valid whenever it holds an entry and shows
//   that entry on rd_data/rd_break/rd_ext (all zero when empty). rd_valid
//   never waits for rd_en. An entry is consumed on a clk edge where
//   rd_en && rd_valid; rd_en while rd_valid is low has no effect.
interface ps2_kbd_fifo_if #(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          rd_break;
    logic          rd_ext;
    logic [CW-1:0] count;

    modport master (
        output rd_en,
        input  rd_valid, rd_data, rd_break, rd_ext, count
    );

    modport slave (
        input  rd_en,
        output rd_valid, rd_data, rd_break, rd_ext, count
    );
endinterface

// File: rtl/ps2_kbd_fifo_sync_fifo.sv
// ps2_kbd_fifo_sync_fifo
//   Single-clock show-ahead FIFO with wrap-bit pointers.
//   Ports: clk, rst (async, active-low), push/din (write), pop (read, ignored
//   when empty), dout (head, zero when empty), count, full, empty.
//   A push while full is accepted only if a pop happens in the same cycle.
module ps2_kbd_fifo_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_kbd_fifo.sv
// ps2_kbd_fifo
//   PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, deframes and
//   checks 11-bit frames, optionally folds E0/F0 prefixes into flags and
//   queues codes in a show-ahead FIFO.
//   Ports: clk, rst (async, active-low), ps2_clk, ps2_data (raw pins),
//   clr_err (clears sticky errors), rd_if (read-side interface, slave),
//   overflow (sticky, code dropped), frame_err (sticky, bad frame/timeout).
module ps2_kbd_fifo
    import ps2_kbd_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000,
    parameter int DECODE_EN   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    input  logic           clr_err,
    ps2_kbd_fifo_if.slave  rd_if,
    output logic           overflow,
    output logic           frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- synchroniser and edge detect ----------------
    // Reset to idle-high so leaving reset never looks like a falling edge.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_cur;
    logic                   data_bit;
    logic                   fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_cur;
        end
    end

    assign clk_cur  = clk_sync[SYNC_STAGES-1];
    assign data_bit = data_sync[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_cur;

    // ---------------- deframer and timeout ----------------
    logic [3:0]    bitcnt;
    logic [9:0]    shift_sr;
    logic [TW-1:0] to_cnt;
    logic          frame_done;
    logic          frame_good;
    logic          frame_bad;
    logic          timeout_hit;
    logic [7:0]    rx_byte;

    assign frame_done  = fall && (bitcnt == 4'(PS2_FRAME_BITS - 1));
    assign frame_good  = frame_done && ps2_frame_ok(shift_sr, data_bit);
    assign frame_bad   = frame_done && !frame_good;
    assign rx_byte     = shift_sr[8:1];
    // The counter hits TIMEOUT_CYC on this cycle if nothing resets it.
    assign timeout_hit = (bitcnt != 4'd0) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitcnt   <= '0;
            shift_sr <= '0;
            to_cnt   <= '0;
        end else if (fall) begin
            to_cnt <= '0;
            if (frame_done) begin
                bitcnt <= '0;
            end else begin
                bitcnt   <= bitcnt + 4'd1;
                // New bit enters at the top; after ten bits the start bit
                // has reached shift_sr[0].
                shift_sr <= {data_bit, shift_sr[9:1]};
            end
        end else if (timeout_hit) begin
            bitcnt <= '0;
            to_cnt <= '0;
        end else if (bitcnt != 4'd0) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    // ---------------- prefix decoder ----------------
    logic       ext_pend;
    logic       brk_pend;
    logic       is_prefix;
    logic       push_req;
    ps2_entry_t push_entry;

    assign is_prefix = (DECODE_EN != 0) &&
                       ((rx_byte == PS2_PREFIX_EXT) || (rx_byte == PS2_PREFIX_BRK));
    assign push_req  = frame_good && !is_prefix;

    always_comb begin
        push_entry      = '0;
        push_entry.code = rx_byte;
        if (DECODE_EN != 0) begin
            push_entry.ext = ext_pend;
            push_entry.brk = brk_pend;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (frame_good && (DECODE_EN != 0)) begin
            if (rx_byte == PS2_PREFIX_EXT) begin
                ext_pend <= 1'b1;
            end else if (rx_byte == PS2_PREFIX_BRK) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // ---------------- queue ----------------
    ps2_entry_t    head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          drop_evt;

    ps2_kbd_fifo_sync_fifo #(
        .WIDTH (PS2_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (rd_if.rd_en),
        .din   (push_entry),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // When full the FIFO is non-empty, so rd_en alone means a pop.
    assign drop_evt = push_req && fifo_full && !rd_if.rd_en;

    assign rd_if.rd_valid = ~fifo_empty;
    assign rd_if.rd_data  = head.code;
    assign rd_if.rd_break = head.brk;
    assign rd_if.rd_ext   = head.ext;
    assign rd_if.count    = fifo_count;

    // ---------------- sticky errors: a new event beats clr_err ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop_evt)     overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;

            if (frame_bad || timeout_hit) frame_err <= 1'b1;
            else if (clr_err)             frame_err <= 1'b0;
        end
    end

endmodule
